// File: rtl/sap1_pkg.sv
// Shared constants and types for the SAP-1 datapath: opcode values, default widths
// and the packed control word issued by the sequencer each T-state.
package sap1_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  localparam logic [3:0] LDA  = 4'b0001;
  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0011;
  localparam logic [3:0] OUT  = 4'b0100;
  localparam logic [3:0] HALT = 4'b1111;

  typedef struct packed {
    logic cp;
    logic ep;
    logic mi;
    logic ro;
    logic ii;
    logic io;
    logic ai;
    logic ao;
    logic su;
    logic eu;
    logic bi;
    logic oi;
  } ctrl_word_t;

  // True when more than one bus source is enabled in the same control word.
  function automatic logic multi_drive(input ctrl_word_t c);
    logic [2:0] n;
    n = 3'(c.ep) + 3'(c.ro) + 3'(c.io) + 3'(c.ao) + 3'(c.eu);
    return n > 3'd1;
  endfunction

endpackage

// File: rtl/sap1_ram.sv
// 2**ADDR_W x DATA_W program/data memory: asynchronous read, synchronous write.
module sap1_ram
  import sap1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // NOTE: storage has no reset so it maps onto plain RAM; non-blocking write keeps
  // a same-cycle read returning the old word.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 register/bus datapath executing one sequencer control word per clock.
// Optional macro SAP1_BUS_CHECK_EN adds a sticky bus_error output for bus contention.
module sap1_datapath
  import sap1_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clock,
  input  logic              Clear_n,
  input  logic              CP,
  input  logic              EP,
  input  logic              MI,
  input  logic              RO,
  input  logic              II,
  input  logic              IO,
  input  logic              AI,
  input  logic              AO,
  input  logic              SU,
  input  logic              EU,
  input  logic              BI,
  input  logic              OI,
  input  logic              HLT,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] out_reg,
  output logic [DATA_W-1:0] bus,
`ifdef SAP1_BUS_CHECK_EN
  output logic              bus_error,
`endif
  output logic              carry,
  output logic              zero
);

  ctrl_word_t ctrl;
  assign ctrl = '{cp: CP, ep: EP, mi: MI, ro: RO, ii: II, io: IO,
                  ai: AI, ao: AO, su: SU, eu: EU, bi: BI, oi: OI};

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic              carry_q, carry_d, zero_q, zero_d;
  logic [DATA_W-1:0] ram_rdata, b_operand, alu_sum, bus_mux;
  logic              alu_carry;

  sap1_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (Clock),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (mar_q),
    .rdata (ram_rdata)
  );

  // Subtract is A + ~B + 1, so carry-out set means no borrow (A >= B).
  always_comb begin
    b_operand = ctrl.su ? ~b_q : b_q;
    {alu_carry, alu_sum} = {1'b0, a_q} + {1'b0, b_operand} + (DATA_W+1)'(ctrl.su);
  end

  // NOTE: every path assigns bus_mux via the leading default, so no latch is inferred.
  always_comb begin
    bus_mux = '0;
    if (ctrl.eu)      bus_mux = alu_sum;
    else if (ctrl.ao) bus_mux = a_q;
    else if (ctrl.ro) bus_mux = ram_rdata;
    else if (ctrl.io) bus_mux = DATA_W'(ir_q[ADDR_W-1:0]);
    else if (ctrl.ep) bus_mux = DATA_W'(pc_q);
  end

  always_comb begin
    pc_d    = pc_q;
    mar_d   = mar_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    if (!HLT) begin
      if (ctrl.cp) pc_d  = pc_q + ADDR_W'(1);
      if (ctrl.mi) mar_d = bus_mux[ADDR_W-1:0];
      if (ctrl.ii) ir_d  = bus_mux;
      if (ctrl.ai) a_d   = bus_mux;
      if (ctrl.bi) b_d   = bus_mux;
      if (ctrl.oi) out_d = bus_mux;
      if (ctrl.eu && ctrl.ai) begin
        carry_d = alu_carry;
        zero_d  = (alu_sum == '0);
      end
    end
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      pc_q    <= '0;
      mar_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      mar_q   <= mar_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

`ifdef SAP1_BUS_CHECK_EN
  logic bus_err_q, bus_err_d;

  assign bus_err_d = bus_err_q | multi_drive(ctrl);

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) bus_err_q <= 1'b0;
    else          bus_err_q <= bus_err_d;
  end

  assign bus_error = bus_err_q;
`endif

  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign out_reg = out_q;
  assign bus     = bus_mux;
  assign carry   = carry_q;
  assign zero    = zero_q;

endmodule
